// File: rtl/util_upack2_ts_pkg.sv
// util_upack2_ts_pkg
// Shared types and helpers for the timestamp gate in front of the channel
// unpacker.
//   state_t   : gate FSM states
//   TS_WIDTH  : width of the release timestamp and sample-time counter
//   spb_t     : samples-per-beat value with its valid flag
//   calc_spb  : samples per beat for a given enabled-channel count
package util_upack2_ts_pkg;

  localparam int TS_WIDTH  = 64;
  localparam int SPB_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PASS = 2'd2,
    DROP = 2'd3
  } state_t;

  typedef struct packed {
    logic [SPB_WIDTH-1:0] spb;
    logic                 valid;
  } spb_t;

  // A beat holds data_width/sample_width sample lanes. The count is usable
  // only when it is non-zero and splits those lanes into whole samples.
  function automatic spb_t calc_spb(input int unsigned count,
                                    input int unsigned data_width,
                                    input int unsigned sample_width);
    int unsigned lanes;
    spb_t        r;
    lanes   = data_width / sample_width;
    r.spb   = '0;
    r.valid = 1'b0;
    if (count != 0) begin
      if ((lanes % count) == 0) begin
        r.spb   = SPB_WIDTH'(lanes / count);
        r.valid = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/util_upack2_ts_spb.sv
// util_upack2_ts_spb
// Registered lookup from the enabled-channel count to samples per beat.
// Every possible count value gets a constant table entry; the selected entry
// is registered each cycle so it is settled when a header is accepted.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enabled_count  : number of enabled channels
//   spb            : samples per beat for the registered count
//   spb_valid      : registered count is a usable configuration
module util_upack2_ts_spb
  import util_upack2_ts_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int DATA_WIDTH      = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [$clog2(NUM_OF_CHANNELS):0]     enabled_count,
  output logic [SPB_WIDTH-1:0]                 spb,
  output logic                                 spb_valid
);

  localparam int CW      = $clog2(NUM_OF_CHANNELS) + 1;
  localparam int ENTRIES = 2 ** CW;

  spb_t lut [ENTRIES];
  spb_t spb_reg;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_lut
    assign lut[gi] = calc_spb(gi, DATA_WIDTH, SAMPLE_WIDTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spb_reg <= '0;
    end else begin
      spb_reg <= lut[enabled_count];
    end
  end

  assign spb       = spb_reg.spb;
  assign spb_valid = spb_reg.valid;

endmodule

// File: rtl/util_upack2_ts_gate.sv
// util_upack2_ts_gate
// Holds each DMA packet until the local sample-time counter reaches the
// release timestamp carried in the packet's first beat, then forwards the
// payload beats unchanged to the channel unpacker.
// Optional feature macro: UTIL_UPACK2_TS_LATE_DROP_EN
//   defined   : late packets are dropped
//   undefined : late packets are flagged but forwarded immediately
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   enabled_count   : enabled channel count, sampled at header acceptance
//   time_now        : sample-time counter
//   s_axis_*        : upstream stream (header beat + payload beats)
//   m_axis_*        : unpacker-side stream
//   sample_count    : total samples forwarded (wraps modulo 2^64)
//   late            : one-cycle pulse per late packet
//   config_error    : high while the latched channel count is invalid
module util_upack2_ts_gate
  import util_upack2_ts_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int DATA_WIDTH      = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(NUM_OF_CHANNELS):0] enabled_count,
  input  logic [TS_WIDTH-1:0]              time_now,
  input  logic                             s_axis_valid,
  output logic                             s_axis_ready,
  input  logic [DATA_WIDTH-1:0]            s_axis_data,
  input  logic                             s_axis_last,
  output logic                             m_axis_valid,
  input  logic                             m_axis_ready,
  output logic [DATA_WIDTH-1:0]            m_axis_data,
  output logic                             m_axis_last,
  output logic [TS_WIDTH-1:0]              sample_count,
  output logic                             late,
  output logic                             config_error
);

  state_t               state_reg, state_next;
  logic [TS_WIDTH-1:0]  ts_reg;
  logic [SPB_WIDTH-1:0] spb_reg;
  logic [TS_WIDTH-1:0]  sample_count_reg;
  logic                 first_wait_reg;
  logic                 late_reg, late_next;
  logic                 config_error_reg;
  logic [SPB_WIDTH-1:0] lut_spb;
  logic                 lut_valid;

  util_upack2_ts_spb #(
    .NUM_OF_CHANNELS (NUM_OF_CHANNELS),
    .SAMPLE_WIDTH    (SAMPLE_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_spb (
    .clk           (clk),
    .reset         (reset),
    .enabled_count (enabled_count),
    .spb           (lut_spb),
    .spb_valid     (lut_valid)
  );

  logic s_hs;
  assign s_hs = s_axis_valid && s_axis_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    s_axis_ready = 1'b0;
    m_axis_valid = 1'b0;
    m_axis_data  = '0;
    m_axis_last  = 1'b0;
    late_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        s_axis_ready = 1'b1;
        if (s_axis_valid) begin
          // A header that is also the last beat carries no payload.
          if (s_axis_last) begin
            state_next = IDLE;
          end else if (!lut_valid) begin
            state_next = DROP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // Lateness is only judged on the first WAIT cycle; afterwards the
        // counter can at most reach the timestamp, which releases the packet.
        if (first_wait_reg && (time_now > ts_reg)) begin
          late_next = 1'b1;
`ifdef UTIL_UPACK2_TS_LATE_DROP_EN
          state_next = DROP;
`else
          state_next = PASS;
`endif
        end else if (time_now >= ts_reg) begin
          state_next = PASS;
        end
      end
      PASS: begin
        m_axis_valid = s_axis_valid;
        s_axis_ready = m_axis_ready;
        m_axis_data  = s_axis_data;
        m_axis_last  = s_axis_last;
        if (s_axis_valid && m_axis_ready && s_axis_last) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        s_axis_ready = 1'b1;
        if (s_axis_valid && s_axis_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_reg           <= '0;
      spb_reg          <= '0;
      sample_count_reg <= '0;
      first_wait_reg   <= 1'b0;
      late_reg         <= 1'b0;
      config_error_reg <= 1'b0;
    end else begin
      late_reg <= late_next;
      case (state_reg)
        IDLE: begin
          if (s_axis_valid) begin
            ts_reg         <= s_axis_data[TS_WIDTH-1:0];
            spb_reg        <= lut_spb;
            first_wait_reg <= 1'b1;
            if (!s_axis_last) begin
              config_error_reg <= !lut_valid;
            end
          end
        end
        WAIT: first_wait_reg <= 1'b0;
        PASS: begin
          if (s_hs) begin
            sample_count_reg <= sample_count_reg + TS_WIDTH'(spb_reg);
          end
        end
        DROP: begin
          if (s_hs && s_axis_last) begin
            config_error_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sample_count = sample_count_reg;
  assign late         = late_reg;
  assign config_error = config_error_reg;

endmodule

// File: tb/tb_util_upack2_ts_gate.sv
// tb_util_upack2_ts_gate
// Directed, table-driven bench for util_upack2_ts_gate with default
// parameters (4 channels, 16-bit samples, 64-bit stream).
module tb_util_upack2_ts_gate;

`ifdef UTIL_UPACK2_TS_LATE_DROP_EN
  localparam bit DROP_LATE = 1'b1;
`else
  localparam bit DROP_LATE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  enabled_count;
  logic [63:0] time_now;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic [63:0] s_axis_data;
  logic        s_axis_last;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic [63:0] m_axis_data;
  logic        m_axis_last;
  logic [63:0] sample_count;
  logic        late;
  logic        config_error;

  util_upack2_ts_gate dut (
    .clk           (clk),
    .reset         (reset),
    .enabled_count (enabled_count),
    .time_now      (time_now),
    .s_axis_valid  (s_axis_valid),
    .s_axis_ready  (s_axis_ready),
    .s_axis_data   (s_axis_data),
    .s_axis_last   (s_axis_last),
    .m_axis_valid  (m_axis_valid),
    .m_axis_ready  (m_axis_ready),
    .m_axis_data   (m_axis_data),
    .m_axis_last   (m_axis_last),
    .sample_count  (sample_count),
    .late          (late),
    .config_error  (config_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, sampled on the falling edge (inputs change just after
  // the rising edge, so each cycle is seen exactly once).
  int          late_cnt;
  logic [63:0] late_time;
  logic [63:0] first_fwd;
  bit          cfg_seen;
  bit          mvalid_seen;
  logic [63:0] data_q [$];
  bit          last_q [$];

  always @(negedge clk) begin
    if (!reset) begin
      if (late) begin
        late_cnt  = late_cnt + 1;
        late_time = time_now;
      end
      if (config_error) cfg_seen = 1'b1;
      if (m_axis_valid) mvalid_seen = 1'b1;
      if (m_axis_valid && m_axis_ready) begin
        data_q.push_back(m_axis_data);
        last_q.push_back(m_axis_last);
        if (first_fwd == 64'd0) first_fwd = time_now;
      end
    end
  end

  bit       rdy_toggle;
  int       rdy_idx;
  bit [3:0] rdy_pat;

  typedef struct {
    logic [2:0]  cnt;
    logic [63:0] t0;
    logic [63:0] ts;
    int          nb;
    logic [63:0] base;
    bit          toggle;
    int          exp_late;
    int          exp_fwd;
    logic [63:0] exp_delta;
    bit          exp_cfg;
    logic [63:0] exp_first;  // 0 = not checked
  } vec_t;

  vec_t        vecs [10];
  logic [63:0] exp_sc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    time_now = time_now + 64'd1;
    if (rdy_toggle) begin
      m_axis_ready = rdy_pat[rdy_idx];
      rdy_idx      = (rdy_idx + 1) % 4;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int guard;
    bit done;
    guard = 0;
    done  = 1'b0;
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_last  = l;
    while (!done && guard < 200) begin
      #1;
      done = s_axis_ready;
      tick();
      guard++;
    end
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: got no handshake expected handshake for data 0x%0h", d);
    end
  endtask

  task automatic clear_mon();
    late_cnt    = 0;
    late_time   = 64'd0;
    first_fwd   = 64'd0;
    cfg_seen    = 1'b0;
    mvalid_seen = 1'b0;
    data_q.delete();
    last_q.delete();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    enabled_count = v.cnt;
    m_axis_ready  = 1'b1;
    tick();
    tick();
    clear_mon();
    rdy_idx    = 0;
    rdy_toggle = v.toggle;
    time_now   = v.t0;
    send_beat(v.ts, (v.nb == 0));
    for (int i = 0; i < v.nb; i++) begin
      send_beat(v.base + 64'(i), (i == v.nb - 1));
    end
    rdy_toggle   = 1'b0;
    m_axis_ready = 1'b1;
    repeat (3) tick();
    exp_sc = exp_sc + v.exp_delta;
    $display("vector %0d: cnt=%0d ts=%0d beats=%0d fwd=%0d late=%0d cfg=%0d sample_count=%0d",
             idx, v.cnt, v.ts, v.nb, data_q.size(), late_cnt, cfg_seen, sample_count);
    chk($sformatf("v%0d_late_count", idx), 64'(late_cnt), 64'(v.exp_late));
    if (v.exp_late > 0)
      chk($sformatf("v%0d_late_time", idx), late_time, v.t0 + 64'd2);
    chk($sformatf("v%0d_fwd_beats", idx), 64'(data_q.size()), 64'(v.exp_fwd));
    chk($sformatf("v%0d_mvalid_seen", idx), 64'(mvalid_seen), 64'(v.exp_fwd > 0));
    for (int i = 0; i < data_q.size(); i++) begin
      chk($sformatf("v%0d_data%0d", idx, i), data_q[i], v.base + 64'(i));
      chk($sformatf("v%0d_last%0d", idx, i), 64'(last_q[i]), 64'(i == v.nb - 1));
    end
    if (v.exp_first != 64'd0)
      chk($sformatf("v%0d_first_fwd_time", idx), first_fwd, v.exp_first);
    chk($sformatf("v%0d_sample_count", idx), sample_count, exp_sc);
    chk($sformatf("v%0d_cfg_seen", idx), 64'(cfg_seen), 64'(v.exp_cfg));
    chk($sformatf("v%0d_cfg_cleared", idx), 64'(config_error), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    enabled_count = 3'd4;
    time_now      = 64'd0;
    s_axis_valid  = 1'b0;
    s_axis_data   = 64'd0;
    s_axis_last   = 1'b0;
    m_axis_ready  = 1'b1;
    rdy_toggle    = 1'b0;
    rdy_idx       = 0;
    rdy_pat       = 4'b1001;  // bits 0..3 = 1,0,0,1
    exp_sc        = 64'd0;
    clear_mon();

    //        cnt   t0     ts     nb base      tg late fwd                  delta                 cfg first
    vecs[0] = '{3'd4, 64'd100, 64'd110, 3, 64'hA000, 1'b0, 0, 3, 64'd3, 1'b0, 64'd111};
    vecs[1] = '{3'd1, 64'd300, 64'd305, 2, 64'hA100, 1'b0, 0, 2, 64'd8, 1'b0, 64'd306};
    vecs[2] = '{3'd4, 64'd60,  64'd50,  2, 64'hA200, 1'b0, 1, DROP_LATE ? 0 : 2,
                DROP_LATE ? 64'd0 : 64'd2, 1'b0, DROP_LATE ? 64'd0 : 64'd62};
    vecs[3] = '{3'd3, 64'd400, 64'd410, 2, 64'hA300, 1'b0, 0, 0, 64'd0, 1'b1, 64'd0};
    vecs[4] = '{3'd2, 64'd500, 64'd501, 3, 64'hA400, 1'b0, 0, 3, 64'd6, 1'b0, 64'd502};
    vecs[5] = '{3'd4, 64'd600, 64'd600, 1, 64'hA500, 1'b0, 1, DROP_LATE ? 0 : 1,
                DROP_LATE ? 64'd0 : 64'd1, 1'b0, DROP_LATE ? 64'd0 : 64'd602};
    vecs[6] = '{3'd0, 64'd650, 64'd655, 1, 64'hA600, 1'b0, 0, 0, 64'd0, 1'b1, 64'd0};
    vecs[7] = '{3'd4, 64'd700, 64'd700, 0, 64'hA700, 1'b0, 0, 0, 64'd0, 1'b0, 64'd0};
    vecs[8] = '{3'd4, 64'd800, 64'd803, 4, 64'hA800, 1'b1, 0, 4, 64'd4, 1'b0, 64'd0};
    vecs[9] = '{3'd2, 64'd850, 64'd860, 2, 64'hA900, 1'b0, 0, 2, 64'd4, 1'b0, 64'd861};

    #3;
    chk("reset_s_ready", 64'(s_axis_ready), 64'd1);
    chk("reset_m_valid", 64'(m_axis_valid), 64'd0);
    chk("reset_m_last", 64'(m_axis_last), 64'd0);
    chk("reset_m_data", m_axis_data, 64'd0);
    chk("reset_sample_count", sample_count, 64'd0);
    chk("reset_late", 64'(late), 64'd0);
    chk("reset_config_error", 64'(config_error), 64'd0);
    $display("reset state checked");
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset in the middle of a forwarded packet (1 of 4 beats sent).
    enabled_count = 3'd4;
    tick();
    tick();
    clear_mon();
    time_now = 64'd900;
    send_beat(64'd901, 1'b0);
    send_beat(64'hB000, 1'b0);
    exp_sc = exp_sc + 64'd1;
    chk("midreset_pre_sample_count", sample_count, exp_sc);
    chk("midreset_pre_fwd", 64'(data_q.size()), 64'd1);
    s_axis_valid = 1'b1;
    s_axis_data  = 64'hB001;
    s_axis_last  = 1'b0;
    reset = 1'b1;
    #1;
    exp_sc = 64'd0;
    $display("reset asserted mid-packet: m_valid=%0d s_ready=%0d sample_count=%0d",
             m_axis_valid, s_axis_ready, sample_count);
    chk("midreset_m_valid", 64'(m_axis_valid), 64'd0);
    chk("midreset_s_ready", 64'(s_axis_ready), 64'd1);
    chk("midreset_m_data", m_axis_data, 64'd0);
    chk("midreset_m_last", 64'(m_axis_last), 64'd0);
    chk("midreset_sample_count", sample_count, 64'd0);
    chk("midreset_late", 64'(late), 64'd0);
    s_axis_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // The next beat after reset must be taken as a header (not forwarded).
    begin
      vec_t v;
      v = '{3'd4, 64'd950, 64'd953, 2, 64'hC000, 1'b0, 0, 2, 64'd2, 1'b0, 64'd954};
      run_vec(10, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
